// File: rtl/tdm_pkg.sv
// tdm_pkg
// Types and constants shared by the TDM slot serialiser (4:1 mux) and
// deserialiser (1:4 demux). Keeping them in one place ensures both ends agree
// on the frame geometry and the slot encoding.
//
//   slot_t  : slot index within a frame (0..NSLOT-1)
//   state_t : frame alignment state of the receive side
//   NSLOT   : slots per frame; fixed at 4 because slot_t is 2 bits wide
package tdm_pkg;

  localparam int NSLOT = 4;

  typedef logic [1:0] slot_t;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam slot_t LAST_SLOT = slot_t'(NSLOT - 1);

  // Next slot in frame order; wraps from the last slot back to 0.
  function automatic slot_t slot_next(input slot_t s);
    return (s == LAST_SLOT) ? slot_t'(0) : slot_t'(s + slot_t'(1));
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr
// Slot position counter for the TDM demux.
//
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset, clears slot to 0
//   load1  in   a slot-0 beat was accepted; the next beat goes to slot 1
//   inc    in   a non-zero slot beat was accepted; advance by one with wrap
//   slot   out  index the next accepted beat is written to
//   wrap   out  combinational strobe: inc while slot is the last slot
//
// load1 has priority over inc; the controller never asserts both.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load1,
  input  logic  inc,
  output slot_t slot,
  output logic  wrap
);

  slot_t slot_q;
  slot_t slot_d;

  always_comb begin
    slot_d = slot_q;
    if (load1) begin
      slot_d = slot_t'(1);
    end else if (inc) begin
      slot_d = slot_next(slot_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= slot_t'(0);
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;
  assign wrap = inc && (slot_q == LAST_SLOT);

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4
// Time-division 1:4 demultiplexer. Serial W-bit slot beats, with a frame
// marker on slot 0, are collected into shadow registers and published to four
// parallel lanes only when a whole frame has arrived, so consumers never see
// lanes from two different frames.
//
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   din          in   slot data (W bits)
//   din_valid    in   din carries a slot beat this cycle
//   frame_sync   in   current beat is slot 0 (ignored without din_valid)
//   d0..d3       out  lanes 0..3 of the last complete frame
//   frame_valid  out  one-cycle pulse: lanes were updated this cycle
//   locked       out  frame alignment acquired
//   slot         out  slot index the next beat will be written to
//   sync_err     out  one-cycle pulse: marker misplaced or missing
//
// state  | meaning
// HUNT   | no alignment; beats without frame_sync are dropped
// LOCKED | aligned; beats fill slots, frame published on slot 3
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         frame_sync,
  output logic [W-1:0] d0,
  output logic [W-1:0] d1,
  output logic [W-1:0] d2,
  output logic [W-1:0] d3,
  output logic         frame_valid,
  output logic         locked,
  output logic [1:0]   slot,
  output logic         sync_err
);

  state_t state_q;
  state_t state_d;

  // Slot 3 is never stored: its beat goes straight to lane 3 together with
  // the three shadowed slots.
  logic [W-1:0] shadow_q [3];
  logic [W-1:0] shadow_d [3];
  logic [W-1:0] lane_q   [4];
  logic [W-1:0] lane_d   [4];

  logic frame_valid_q;
  logic frame_valid_d;
  logic sync_err_q;
  logic sync_err_d;

  slot_t slot_cur;
  logic  slot_wrap;
  logic  ctr_load1;
  logic  ctr_inc;

  // Beat classification.
  logic hunt_sync;  // marker seen while hunting: acquire alignment
  logic lk_sync;    // marker while locked: (re)start frame at slot 0
  logic lk_data;    // ordinary data beat into slots 1..3
  logic lk_lost;    // slot-0 beat without marker: alignment lost
  logic slot_zero;

  assign slot_zero = (slot_cur == slot_t'(0));
  assign hunt_sync = din_valid && (state_q == HUNT) && frame_sync;
  assign lk_sync   = din_valid && (state_q == LOCKED) && frame_sync;
  assign lk_data   = din_valid && (state_q == LOCKED) && !frame_sync && !slot_zero;
  assign lk_lost   = din_valid && (state_q == LOCKED) && !frame_sync && slot_zero;

  assign ctr_load1 = hunt_sync || lk_sync;
  assign ctr_inc   = lk_data;

  tdm_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .load1 (ctr_load1),
    .inc   (ctr_inc),
    .slot  (slot_cur),
    .wrap  (slot_wrap)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HUNT: begin
        if (hunt_sync) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (lk_lost) begin
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    shadow_d      = shadow_q;
    lane_d        = lane_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;

    if (ctr_load1) begin
      // A misplaced marker restarts the frame here; the stale shadows for
      // slots 1..2 are overwritten before the next publish.
      shadow_d[0] = din;
    end

    if (lk_data) begin
      case (slot_cur)
        2'd1:    shadow_d[1] = din;
        2'd2:    shadow_d[2] = din;
        default: ;
      endcase
    end

    if (slot_wrap) begin
      lane_d[0]     = shadow_q[0];
      lane_d[1]     = shadow_q[1];
      lane_d[2]     = shadow_q[2];
      lane_d[3]     = din;
      frame_valid_d = 1'b1;
    end

    sync_err_d = (lk_sync && !slot_zero) || lk_lost;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        shadow_q[i] <= '0;
      end
      for (int i = 0; i < 4; i++) begin
        lane_q[i] <= '0;
      end
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      lane_q        <= lane_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign d0          = lane_q[0];
  assign d1          = lane_q[1];
  assign d2          = lane_q[2];
  assign d3          = lane_q[3];
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == LOCKED);
  assign slot        = slot_cur;

endmodule

// File: tb/tb_tdm_demux4.sv
module tb_tdm_demux4;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         frame_sync = 1'b0;
  logic [W-1:0] d0, d1, d2, d3;
  logic         frame_valid;
  logic         locked;
  logic [1:0]   slot;
  logic         sync_err;

  int checks = 0;
  int errors = 0;

  tdm_demux4 #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .d0          (d0),
    .d1          (d1),
    .d2          (d2),
    .d3          (d3),
    .frame_valid (frame_valid),
    .locked      (locked),
    .slot        (slot),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_lanes(input string tag, input logic [W-1:0] e0, input logic [W-1:0] e1,
                           input logic [W-1:0] e2, input logic [W-1:0] e3);
    chk({tag, ".d0"}, 32'(d0), 32'(e0));
    chk({tag, ".d1"}, 32'(d1), 32'(e1));
    chk({tag, ".d2"}, 32'(d2), 32'(e2));
    chk({tag, ".d3"}, 32'(d3), 32'(e3));
  endtask

  task automatic chk_ctl(input string tag, input logic e_fv, input logic e_se,
                         input logic e_lk, input logic [1:0] e_slot);
    chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(e_fv));
    chk({tag, ".sync_err"},    32'(sync_err),    32'(e_se));
    chk({tag, ".locked"},      32'(locked),      32'(e_lk));
    chk({tag, ".slot"},        32'(slot),        32'(e_slot));
  endtask

  // Called at a falling edge; drives one beat, returns at the next falling
  // edge where the result of that beat is visible.
  task automatic beat(input logic [W-1:0] d, input logic s);
    din        = d;
    din_valid  = 1'b1;
    frame_sync = s;
    @(negedge clk);
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    din        = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    // Reset state.
    #1;
    chk_lanes("rst", 4'h0, 4'h0, 4'h0, 4'h0);
    chk_ctl("rst", 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame 6,7,9,3.
    beat(4'h6, 1'b1);
    chk_ctl("f1.b0", 1'b0, 1'b0, 1'b1, 2'd1);
    beat(4'h7, 1'b0);
    beat(4'h9, 1'b0);
    chk_ctl("f1.b2", 1'b0, 1'b0, 1'b1, 2'd3);
    chk_lanes("f1.b2", 4'h0, 4'h0, 4'h0, 4'h0);
    beat(4'h3, 1'b0);
    chk_lanes("f1.done", 4'h6, 4'h7, 4'h9, 4'h3);
    chk_ctl("f1.done", 1'b1, 1'b0, 1'b1, 2'd0);
    idle(1);
    chk_ctl("f1.after", 1'b0, 1'b0, 1'b1, 2'd0);
    chk_lanes("f1.after", 4'h6, 4'h7, 4'h9, 4'h3);

    // Same frame with two idle cycles between 7 and 9.
    do_reset();
    beat(4'h6, 1'b1);
    beat(4'h7, 1'b0);
    idle(1);
    chk_ctl("gap.i1", 1'b0, 1'b0, 1'b1, 2'd2);
    idle(1);
    chk_ctl("gap.i2", 1'b0, 1'b0, 1'b1, 2'd2);
    chk_lanes("gap.i2", 4'h0, 4'h0, 4'h0, 4'h0);
    beat(4'h9, 1'b0);
    chk_ctl("gap.b2", 1'b0, 1'b0, 1'b1, 2'd3);
    beat(4'h3, 1'b0);
    chk_lanes("gap.done", 4'h6, 4'h7, 4'h9, 4'h3);
    chk_ctl("gap.done", 1'b1, 1'b0, 1'b1, 2'd0);

    // Unsynced beats in HUNT are dropped.
    do_reset();
    beat(4'h5, 1'b0);
    chk_ctl("hunt.5", 1'b0, 1'b0, 1'b0, 2'd0);
    beat(4'h8, 1'b0);
    chk_ctl("hunt.8", 1'b0, 1'b0, 1'b0, 2'd0);
    chk_lanes("hunt.8", 4'h0, 4'h0, 4'h0, 4'h0);
    beat(4'h1, 1'b1);
    beat(4'h2, 1'b0);
    beat(4'h4, 1'b0);
    beat(4'h8, 1'b0);
    chk_lanes("hunt.frame", 4'h1, 4'h2, 4'h4, 4'h8);
    chk_ctl("hunt.frame", 1'b1, 1'b0, 1'b1, 2'd0);

    // Misplaced marker restarts the frame.
    beat(4'h6, 1'b1);
    beat(4'h7, 1'b0);
    beat(4'h9, 1'b0);
    beat(4'h3, 1'b0);
    chk_lanes("mis.base", 4'h6, 4'h7, 4'h9, 4'h3);
    beat(4'hA, 1'b1);
    beat(4'hB, 1'b0);
    chk_ctl("mis.B", 1'b0, 1'b0, 1'b1, 2'd2);
    beat(4'hC, 1'b1);
    chk_ctl("mis.C", 1'b0, 1'b1, 1'b1, 2'd1);
    chk_lanes("mis.C", 4'h6, 4'h7, 4'h9, 4'h3);
    beat(4'hD, 1'b0);
    chk_ctl("mis.D", 1'b0, 1'b0, 1'b1, 2'd2);
    beat(4'hE, 1'b0);
    chk_lanes("mis.E", 4'h6, 4'h7, 4'h9, 4'h3);
    beat(4'hF, 1'b0);
    chk_lanes("mis.F", 4'hC, 4'hD, 4'hE, 4'hF);
    chk_ctl("mis.F", 1'b1, 1'b0, 1'b1, 2'd0);

    // Missing marker at slot 0 drops lock.
    beat(4'h2, 1'b0);
    chk_ctl("lost", 1'b0, 1'b1, 1'b0, 2'd0);
    chk_lanes("lost", 4'hC, 4'hD, 4'hE, 4'hF);
    idle(1);
    chk_ctl("lost.after", 1'b0, 1'b0, 1'b0, 2'd0);

    // Asynchronous reset mid-frame.
    beat(4'h6, 1'b1);
    beat(4'h7, 1'b0);
    chk_ctl("async.pre", 1'b0, 1'b0, 1'b1, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_lanes("async.now", 4'h0, 4'h0, 4'h0, 4'h0);
    chk_ctl("async.now", 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    beat(4'h9, 1'b0);
    beat(4'h3, 1'b0);
    chk_ctl("async.post", 1'b0, 1'b0, 1'b0, 2'd0);
    idle(1);
    chk_ctl("async.idle", 1'b0, 1'b0, 1'b0, 2'd0);
    chk_lanes("async.idle", 4'h0, 4'h0, 4'h0, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
